// File: rtl/countdown_sequencer_if.sv
// Control/status bundle between user logic (master) and countdown_sequencer (slave).
interface countdown_sequencer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned RND_W = 3
);
  logic             start;
  logic [WIDTH-1:0] period;
  logic [RND_W-1:0] rounds;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tick;
  logic             done;
  logic             err;

  modport master (
    output start, period, rounds, pause, abort,
    input  count, busy, tick, done, err
  );

  modport slave (
    input  start, period, rounds, pause, abort,
    output count, busy, tick, done, err
  );
endinterface

// File: rtl/countdown_sequencer.sv
// Multi-round preset/down-counter sequencer: IDLE -> LOAD -> RUN -> DONE, all outputs registered.
// Optional COUNTDOWN_SEQ_AUTORELOAD_EN: DONE re-enters LOAD with the latched period/rounds.
module countdown_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned RND_W = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  countdown_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic [RND_W-1:0] rnd_left, rnd_nxt;
  logic [WIDTH-1:0] period_l, period_nxt;
  logic [RND_W-1:0] rounds_l, rounds_nxt;
  logic             busy_q, tick_q, done_q, err_q;
  logic             tick_nxt, done_nxt, err_nxt;

  // Outputs in a given cycle reflect the decision taken in the previous cycle.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count_q;
    rnd_nxt    = rnd_left;
    period_nxt = period_l;
    rounds_nxt = rounds_l;
    tick_nxt   = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;

    if (bus.abort) begin
      state_nxt = S_IDLE;
      count_nxt = '1;
    end else begin
      unique case (state)
        S_IDLE: begin
          count_nxt = '1;
          if (bus.start) begin
            if ((bus.period != '0) && (bus.rounds != '0)) begin
              period_nxt = bus.period;
              rounds_nxt = bus.rounds;
              state_nxt  = S_LOAD;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end

        S_LOAD: begin
          count_nxt = period_l;
          rnd_nxt   = rounds_l;
          state_nxt = S_RUN;
        end

        S_RUN: begin
          if (!bus.pause) begin
            if (count_q != '0) begin
              count_nxt = count_q - WIDTH'(1);
            end else begin
              tick_nxt = 1'b1;
              // <= 1 rather than == 1 so a zero round count can never wrap
              if (rnd_left <= RND_W'(1)) begin
                done_nxt  = 1'b1;
                state_nxt = S_DONE;
              end else begin
                rnd_nxt   = rnd_left - RND_W'(1);
                count_nxt = period_l;
              end
            end
          end
        end

        S_DONE: begin
`ifdef COUNTDOWN_SEQ_AUTORELOAD_EN
          state_nxt = S_LOAD;
`else
          state_nxt = S_IDLE;
          count_nxt = '1;
`endif
        end

        default: begin
          state_nxt = S_IDLE;
          count_nxt = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      count_q  <= '1;
      rnd_left <= '0;
      period_l <= '0;
      rounds_l <= '0;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      count_q  <= count_nxt;
      rnd_left <= rnd_nxt;
      period_l <= period_nxt;
      rounds_l <= rounds_nxt;
      busy_q   <= (state_nxt != S_IDLE);
      tick_q   <= tick_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.tick  = tick_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule
